// File: rtl/spike_event_encoder_if.sv
// Address-event stream carrying {timestamp, channel} words
// from the spike encoder FIFO to the core.
interface spike_event_encoder_if #(
  parameter int EVT_W = 16
);
  logic [EVT_W-1:0] evt_data;
  logic             evt_valid;
  logic             evt_ready;

  modport master (
    output evt_data,
    output evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_data,
    input  evt_valid,
    output evt_ready
  );
endinterface

// File: rtl/spike_event_encoder.sv
// Spike edge detector, round-robin arbiter and event FIFO
// producing timestamped address-event words.
module spike_event_encoder #(
  parameter int NUM_CH     = 16,
  parameter int TS_WIDTH   = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             spike_in,
  spike_event_encoder_if.master         evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          overflow,
  input  logic                          clear_stats
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int EVT_W = TS_WIDTH + CH_W;
  localparam int AW    = $clog2(FIFO_DEPTH);

  logic [TS_WIDTH-1:0] ts;
  logic [NUM_CH-1:0]   spike_prev;
  logic [NUM_CH-1:0]   pending;
  logic [CH_W-1:0]     rr_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [EVT_W-1:0]    mem [FIFO_DEPTH];

  logic [NUM_CH-1:0]   edges;
  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   drops;
  logic [CH_W-1:0]     gnt_ch;
  logic [CH_W-1:0]     idx;
  logic                found;
  logic                full;
  logic                push;
  logic                pop;
  logic [CH_W:0]       drop_n;
  logic [CNT_WIDTH:0]  drop_sum;

  assign edges = spike_in & ~spike_prev & {NUM_CH{enable}};
  assign full  = fifo_count == (AW+1)'(FIFO_DEPTH);

  // first pending channel at or above rr_ptr, wrapping
  always_comb begin
    found  = 1'b0;
    gnt_ch = '0;
    idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = rr_ptr + CH_W'(k);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        gnt_ch = idx;
      end
    end
  end

  assign push  = found & ~full;
  assign grant = push ? (NUM_CH'(1) << gnt_ch) : '0;
  assign drops = edges & pending & ~grant;

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_CH; i++)
      drop_n = drop_n + (CH_W+1)'(drops[i]);
  end

  assign drop_sum = {1'b0, drop_count}
                  + (CNT_WIDTH+1)'(drop_n);

  assign evt.evt_valid = fifo_count != '0;
  assign evt.evt_data  = evt.evt_valid ? mem[rd_ptr]
                                       : '0;
  assign pop = evt.evt_valid & evt.evt_ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {ts, gnt_ch};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts         <= '0;
      spike_prev <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      ts         <= ts + 1'b1;
      spike_prev <= spike_in;
      pending    <= (pending & ~grant) | edges;
      if (push) begin
        rr_ptr <= gnt_ch + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (clear_stats) begin
        drop_count <= '0;
        overflow   <= 1'b0;
      end else if (|drops) begin
        drop_count <= drop_sum[CNT_WIDTH] ? '1
                    : drop_sum[CNT_WIDTH-1:0];
        overflow   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: latency, ordering,
// backpressure drops, wrap, enable gating and reset.
module tb_spike_event_encoder;
  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] spike_in;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_count;
  logic        overflow;
  logic        clear_stats;

  int checks;
  int errors;
  logic [15:0] q[$];

  spike_event_encoder_if #(.EVT_W(16)) evt_if ();

  spike_event_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .spike_in    (spike_in),
    .evt         (evt_if),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .clear_stats (clear_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    spike_in = '0;
    evt_if.evt_ready = 1'b0;
    clear_stats = 1'b0;
    enable = 1'b1;
    step();
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    enable = 1'b1;
    spike_in = '0;
    clear_stats = 1'b0;
    evt_if.evt_ready = 1'b0;
    #2;
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_data", evt_if.evt_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 0);

    // single 3-cycle pulse on ch5 starting at ts=10
    do_reset();
    repeat (10) step();
    spike_in = 16'h0020;
    step();
    check("t1_lat1", evt_if.evt_valid, 0);
    step();
    check("t1_valid", evt_if.evt_valid, 1);
    check("t1_data", evt_if.evt_data, 16'h00B5);
    step();
    spike_in = '0;
    repeat (3) step();
    check("t1_once", fifo_count, 1);
    check("t1_drop", drop_count, 0);
    evt_if.evt_ready = 1'b1;
    step();
    check("t1_empty", fifo_count, 0);
    check("t1_edata", evt_if.evt_data, 0);

    // all 16 channels at once, drained each cycle
    do_reset();
    evt_if.evt_ready = 1'b1;
    spike_in = 16'hFFFF;
    step();
    check("t2_lat", evt_if.evt_valid, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("t2_data%0d", i), evt_if.evt_data,
            {12'(1 + i), 4'(i)});
    end
    step();
    check("t2_empty", evt_if.evt_valid, 0);
    check("t2_drop", drop_count, 0);
    spike_in = '0;

    // backpressure: fill, drop, then drain
    do_reset();
    spike_in = 16'h03FF;
    repeat (10) step();
    check("t3_full", fifo_count, 8);
    check("t3_head", evt_if.evt_data, 16'h0010);
    spike_in = '0;
    step();
    spike_in = 16'h0100;
    step();
    check("t3_drop", drop_count, 1);
    check("t3_ovf", overflow, 1);
    spike_in = '0;
    evt_if.evt_ready = 1'b1;
    q.delete();
    for (int k = 0; k < 20; k++) begin
      if (evt_if.evt_valid) q.push_back(evt_if.evt_data);
      step();
    end
    check("t3_n", q.size(), 10);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_ev%0d", i),
            (i < q.size()) ? q[i] : 16'hxxxx,
            {12'(1 + i), 4'(i)});
    check("t3_ev8", (q.size() > 8) ? q[8] : 16'hxxxx, 16'h00D8);
    check("t3_ev9", (q.size() > 9) ? q[9] : 16'hxxxx, 16'h00E9);

    // steady push+pop at 7 entries across ts wrap
    do_reset();
    repeat (4089) step();
    spike_in = 16'hFFFF;
    repeat (8) step();
    check("t4_fill", fifo_count, 7);
    evt_if.evt_ready = 1'b1;
    q.delete();
    for (int k = 0; k < 30; k++) begin
      if (k < 10)
        check($sformatf("t4_cnt%0d", k), fifo_count, 7);
      if (evt_if.evt_valid) q.push_back(evt_if.evt_data);
      step();
    end
    check("t4_n", q.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t4_ev%0d", i),
            (i < q.size()) ? q[i] : 16'hxxxx,
            {12'(4090 + i), 4'(i)});
    spike_in = '0;

    // enable gating
    do_reset();
    enable = 1'b0;
    spike_in = 16'h0008;
    repeat (3) step();
    check("t5_dis", fifo_count, 0);
    enable = 1'b1;
    repeat (3) step();
    check("t5_held", evt_if.evt_valid, 0);
    spike_in = '0;

    // multi-drop, saturation, clear_stats, async reset
    do_reset();
    spike_in = 16'h03FF;
    repeat (10) step();
    check("t6_full", fifo_count, 8);
    spike_in = '0;
    step();
    spike_in = 16'h0300;
    step();
    check("t6_drop2", drop_count, 2);
    for (int i = 0; i < 127; i++) begin
      spike_in = '0;
      step();
      spike_in = 16'h0300;
      step();
    end
    check("t6_sat", drop_count, 255);
    spike_in = '0;
    step();
    spike_in = 16'h0100;
    clear_stats = 1'b1;
    step();
    check("t6_clr_cnt", drop_count, 0);
    check("t6_clr_ovf", overflow, 0);
    clear_stats = 1'b0;
    spike_in = '0;
    step();
    spike_in = 16'h0100;
    step();
    check("t6_redrop", drop_count, 1);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rvalid", evt_if.evt_valid, 0);
    check("t6_rcount", fifo_count, 0);
    check("t6_rdrop", drop_count, 0);
    check("t6_rovf", overflow, 0);
    check("t6_rdata", evt_if.evt_data, 0);
    do_reset();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Downstream stage of the 16 adder_unit spike detectors.
- Converts the 16 per-channel spike_detected levels into a stream of address-event words, each {timestamp, channel}.
- Buffers the words in an internal FIFO for the RISC-V core, which drains them over a valid/ready handshake.
- Counts spikes lost to backpressure.

Parameters:
- NUM_CH, 16: number of spike channels; power of 2; CH_W = log2(NUM_CH) = 4.
- TS_WIDTH, 12: width of the free-running timestamp counter; event word width EVT_W = TS_WIDTH + CH_W = 16.
- FIFO_DEPTH, 8: event FIFO entries; power of 2.
- CNT_WIDTH, 8: width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- enable  input  1  1 = capture new spike edges; 0 = ignore new edges. Pending events and FIFO still drain.
- spike_in  input  NUM_CH  spike_detected levels from the adder units, synchronous to clk.
- evt_data  output  EVT_W  FIFO head word: {timestamp[TS_WIDTH-1:0], channel[CH_W-1:0]}.
- evt_valid  output  1  FIFO non-empty.
- evt_ready  input  1  consumer accepts evt_data when evt_valid & evt_ready at a clk edge.
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- drop_count  output  CNT_WIDTH  saturating count of coalesced (lost) spikes.
- overflow  output  1  sticky; set on any drop.
- clear_stats  input  1  synchronous; clears drop_count and overflow.

Behaviour:
- Reset values: spike_prev, pending, timestamp, rr_ptr, FIFO pointers and fifo_count are 0. Outputs evt_valid=0, evt_data=0, drop_count=0, overflow=0.
- Timestamp: ts increments by 1 every clk cycle and wraps from 2^TS_WIDTH-1 to 0. It runs regardless of enable.
- Edge detect:
  - spike_prev <= spike_in every cycle.
  - edge[i] = spike_in[i] & ~spike_prev[i] & enable.
  - A level held high produces exactly one edge.
- Pending register:
  - pending[i] <= (pending[i] & ~grant[i]) | edge[i].
  - An edge on the channel granted in the same cycle re-sets pending; this is a new event, not a drop.
- Drop: edge[i] & pending[i] & ~grant[i] is a drop. Per cycle, drop_count += popcount(drops), saturating at 2^CNT_WIDTH-1. Any drop sets overflow.
- clear_stats precedence: clear_stats wins over drops in the same cycle (drop_count=0, overflow=0).
- Arbiter:
  - Combinational, round-robin over pending, searching upward from rr_ptr with wrap-around.
  - At most one grant per cycle, and only when the FIFO is not full.
  - A pop in the same cycle does not enable a grant when full.
  - On a grant to channel g: rr_ptr <= (g+1) mod NUM_CH. With no grant, rr_ptr holds.
- Push: on a grant, the FIFO writes {ts, g}, where ts is the counter value before this edge's increment.
- Latency: spike_in rises, sampled at edge k → pending set at k. With no contention and FIFO not full → grant and push at edge k+1 → evt_valid=1 after edge k+1.
- FIFO:
  - Show-ahead: evt_data always shows the head word; evt_data is 0 when empty.
  - Pop on evt_valid & evt_ready. Pop while empty is ignored.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- Full: with fifo_count == FIFO_DEPTH, no grants occur. Pending holds events, and further edges on pending channels are dropped.
- Reset mid-operation: asynchronous clear of all state. Pending events and FIFO contents are discarded and not counted as drops.

Test Plan:
- Reset, then pulse spike_in[5] high for 3 cycles starting at ts=10 → exactly one event 0x0B5 (ts=11, ch=5), evt_valid rises 2 cycles after the input rise, drop_count=0.
- spike_in = 0xFFFF rises in one cycle, evt_ready=1 → 16 events on channels 0,1,…,15 in order, consecutive timestamps, no drops.
- evt_ready=0, channels 0..9 each spike once → FIFO holds 8 events (ch 0..7), fifo_count=8, pending={8,9}. Spike ch 8 again → drop_count=1, overflow=1. Raise evt_ready → ch 8 and ch 9 drain afterwards.
- Continuous pushes with simultaneous pops at FIFO_DEPTH-1 occupancy → fifo_count stays 7, data order preserved across pointer wrap. ts wraps 4095→0 and the event word carries ts=0.
- enable=0 during a spike_in[3] rise → no event. enable=1 with spike_in[3] still high → no event (no new edge).
- Assert reset low mid-stream with a full FIFO → evt_valid=0, fifo_count=0, drop_count=0 immediately, without waiting for a clk edge. Assert clear_stats in the same cycle as a drop → drop_count=0.
